if_fetch_queue: RTL and testbench

Parametrised instruction fetch stage: fetches FETCH_W consecutive instruction words per cycle from instruction memory into a DEPTH-entry circular instruction queue and delivers one instruction per cycle to ID. It decouples IM bandwidth from ID consumption, holds the head instruction under STALL, and flushes and redirects on Request_Alt_PC. It sits between the instruction memory and ID and replaces the single-word fetch stage.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_fetch_queue_fetch_fifo.sv | 57 +++++
 rtl/if_fetch_queue.sv | 73 +++++++
 tb/tb_if_fetch_queue.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch queue.
package if_pkg;

   localparam int unsigned XLEN             = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;
   localparam logic [31:0] NOP              = 32'h0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Circular instruction buffer: FETCH_W entries written per cycle, one read per cycle.
module fetch_fifo
   import if_pkg::*;
#(
   parameter int unsigned FETCH_W = 2,
   parameter int unsigned DEPTH   = 4,
   localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    flush,
   input  logic                    wr_en,
   input  fq_entry_t [FETCH_W-1:0] wr_data,
   input  logic                    rd_en,
   output fq_entry_t               rd_data,
   output logic                    rd_valid,
   output logic [CW-1:0]           free
);

   fq_entry_t     mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          rd_ok;

   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int unsigned off);
      return PW'((32'(base) + off) % DEPTH);
   endfunction

   assign rd_valid = (count != '0);
   assign rd_ok    = rd_en && rd_valid;
   assign rd_data  = mem[head];
   assign free     = CW'(DEPTH) - count;

   always_ff @(posedge CLK) begin
      if (RESET || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (wr_en) tail <= wrap_idx(tail, FETCH_W);
         if (rd_ok) head <= wrap_idx(head, 1);
         count <= count + (wr_en ? CW'(FETCH_W) : CW'(0)) - (rd_ok ? CW'(1) : CW'(0));
      end
   end

   // Storage needs no reset; occupancy is tracked by count alone.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         for (int i = 0; i < int'(FETCH_W); i++) begin
            mem[wrap_idx(tail, i)] <= wr_data[i];
         end
      end
   end

endmodule

// File: rtl/if_fetch_queue.sv
// Multi-word instruction fetch stage feeding ID through a circular queue.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int unsigned FETCH_W  = 2,
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    STALL,
   input  logic                    Request_Alt_PC,
   input  logic [31:0]             Alt_PC,
   output logic [31:0]             Instr_address_2IM,
   output logic                    Fetch_Enable_2IM,
   input  logic [32*FETCH_W-1:0]   Instr_fIM,
   output logic                    Instr_Valid_OUT,
   output logic [31:0]             Instr1_OUT,
   output logic [31:0]             Instr_PC_OUT,
   output logic [31:0]             Instr_PC_Plus4
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [31:0]             fetch_pc;
   logic                    enq;
   logic                    pop;
   logic [CW-1:0]           free;
   logic                    head_valid;
   fq_entry_t               head;
   fq_entry_t [FETCH_W-1:0] wr_data;

   // Free space is judged at cycle start; a same-cycle pop does not make room.
   assign enq = !RESET && !Request_Alt_PC && (32'(free) >= FETCH_W);
   assign pop = head_valid && !STALL && !Request_Alt_PC;

   always_comb begin
      wr_data = '0;
      for (int i = 0; i < int'(FETCH_W); i++) begin
         wr_data[i].pc    = fetch_pc + 32'(4 * i);
         wr_data[i].instr = Instr_fIM[32*i +: 32];
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET)               fetch_pc <= RESET_PC;
      else if (Request_Alt_PC) fetch_pc <= {Alt_PC[31:2], 2'b00};
      else if (enq)            fetch_pc <= fetch_pc + 32'(4 * FETCH_W);
   end

   fetch_fifo #(
      .FETCH_W (FETCH_W),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .CLK      (CLK),
      .RESET    (RESET),
      .flush    (Request_Alt_PC),
      .wr_en    (enq),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (head),
      .rd_valid (head_valid),
      .free     (free)
   );

   assign Instr_address_2IM = fetch_pc;
   assign Fetch_Enable_2IM  = enq;
   assign Instr_Valid_OUT   = head_valid;
   assign Instr1_OUT        = head_valid ? head.instr       : NOP;
   assign Instr_PC_OUT      = head_valid ? head.pc          : NOP;
   assign Instr_PC_Plus4    = head_valid ? head.pc + 32'd4  : NOP;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench: a queue of expected head entries is fed on each modelled fetch and drained on each pop.
module tb_if_fetch_queue;

   localparam int unsigned FW  = 2;
   localparam int unsigned DP  = 4;
   localparam logic [31:0] RPC = 32'hBFC00000;

   logic        CLK = 1'b0;
   logic        RESET, STALL, Request_Alt_PC;
   logic [31:0] Alt_PC;
   logic [31:0] addr_a, instr_a, pc_a, plus4_a;
   logic        en_a, valid_a;
   logic [32*FW-1:0] fim_a;

   logic        reset_b, stall_b, req_b;
   logic [31:0] alt_b;
   logic [31:0] addr_b, instr_b, pc_b, plus4_b;
   logic        en_b, valid_b;
   logic [31:0] fim_b;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [31:0] m_pc;
   logic [31:0] sb_q[$];

   always #5 CLK = ~CLK;

   function automatic logic [31:0] im_word(input logic [31:0] a);
      return a ^ 32'h5A5AC3C3;
   endfunction

   always_comb begin
      fim_a = '0;
      for (int i = 0; i < int'(FW); i++) fim_a[32*i +: 32] = im_word(addr_a + 32'(4 * i));
   end
   assign fim_b = im_word(addr_b);

   if_fetch_queue #(.FETCH_W(FW), .DEPTH(DP)) dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .Request_Alt_PC(Request_Alt_PC), .Alt_PC(Alt_PC),
      .Instr_address_2IM(addr_a), .Fetch_Enable_2IM(en_a), .Instr_fIM(fim_a),
      .Instr_Valid_OUT(valid_a), .Instr1_OUT(instr_a), .Instr_PC_OUT(pc_a), .Instr_PC_Plus4(plus4_a)
   );

   if_fetch_queue #(.FETCH_W(1), .DEPTH(2)) dut_b (
      .CLK(CLK), .RESET(reset_b), .STALL(stall_b), .Request_Alt_PC(req_b), .Alt_PC(alt_b),
      .Instr_address_2IM(addr_b), .Fetch_Enable_2IM(en_b), .Instr_fIM(fim_b),
      .Instr_Valid_OUT(valid_b), .Instr1_OUT(instr_b), .Instr_PC_OUT(pc_b), .Instr_PC_Plus4(plus4_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Called just after a falling edge with inputs applied and settled.
   task automatic check_outputs();
      logic exp_en;
      exp_en = !RESET && !Request_Alt_PC && ((DP - sb_q.size()) >= FW);
      check("fetch_en", 32'(en_a), 32'(exp_en));
      check("im_addr", addr_a, m_pc);
      check("valid", 32'(valid_a), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
         check("pc", pc_a, sb_q[0]);
         check("instr", instr_a, im_word(sb_q[0]));
         check("plus4", plus4_a, sb_q[0] + 32'd4);
      end else begin
         check("pc_empty", pc_a, 32'h0);
         check("instr_empty", instr_a, 32'h0);
         check("plus4_empty", plus4_a, 32'h0);
      end
   endtask

   task automatic model_update();
      logic en, pp;
      if (RESET) begin
         sb_q.delete();
         m_pc = RPC;
      end else if (Request_Alt_PC) begin
         sb_q.delete();
         m_pc = {Alt_PC[31:2], 2'b00};
      end else begin
         en = (DP - sb_q.size()) >= FW;
         pp = (sb_q.size() != 0) && !STALL;
         if (pp) void'(sb_q.pop_front());
         if (en) begin
            for (int i = 0; i < int'(FW); i++) sb_q.push_back(m_pc + 32'(4 * i));
            m_pc = m_pc + 32'(4 * FW);
         end
      end
   endtask

   task automatic step(input logic rst, input logic stall, input logic redir, input logic [31:0] alt);
      RESET = rst; STALL = stall; Request_Alt_PC = redir; Alt_PC = alt;
      #1;
      check_outputs();
      model_update();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      RESET = 1'b1; STALL = 1'b0; Request_Alt_PC = 1'b0; Alt_PC = '0;
      reset_b = 1'b1; stall_b = 1'b0; req_b = 1'b0; alt_b = '0;
      sb_q.delete();
      m_pc = RPC;
      repeat (2) @(posedge CLK);
      @(negedge CLK);

      // Reset state, then free-running fetch
      step(1, 0, 0, 0);
      repeat (8) step(0, 0, 0, 0);

      // Stall from fresh reset: queue fills, fetch halts, then drains in order
      step(1, 0, 0, 0);
      repeat (6) step(0, 1, 0, 0);
      repeat (8) step(0, 0, 0, 0);

      // Redirect under stall with three entries queued
      step(1, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      check("count3_before_redirect", 32'(sb_q.size()), 32'd3);
      step(0, 1, 1, 32'h00400013);
      repeat (4) step(0, 0, 0, 0);

      // Back-to-back redirects; the first target is never fetched
      step(0, 0, 1, 32'h00000100);
      step(0, 0, 1, 32'h00000200);
      repeat (6) step(0, 0, 0, 0);

      // Random stall across pointer wrap
      repeat (40) step(0, 1'($urandom_range(0, 1)), 0, 0);

      // Reset mid-stream while stalled and redirecting
      step(1, 1, 1, 32'h12345678);
      repeat (3) step(0, 0, 0, 0);

      // Single-word fetch, two-entry queue: stream then reset mid-stream
      reset_b = 1'b0;
      #1;
      check("b_en_first", 32'(en_b), 32'd1);
      check("b_addr_first", addr_b, RPC);
      check("b_valid_first", 32'(valid_b), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(posedge CLK); @(negedge CLK); #1;
         check("b_valid", 32'(valid_b), 32'd1);
         check("b_pc", pc_b, RPC + 32'(4 * k));
         check("b_instr", instr_b, im_word(RPC + 32'(4 * k)));
      end
      reset_b = 1'b1;
      #1;
      check("b_en_in_reset", 32'(en_b), 32'd0);
      @(posedge CLK); @(negedge CLK);
      reset_b = 1'b0;
      #1;
      check("b_valid_after_reset", 32'(valid_b), 32'd0);
      check("b_instr_after_reset", instr_b, 32'h0);
      check("b_pc_after_reset", pc_b, 32'h0);
      check("b_plus4_after_reset", plus4_b, 32'h0);
      check("b_addr_after_reset", addr_b, RPC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
